// File: rtl/shift_add_mul.sv
// shift_add_mul: sequential RV32M-style multiplier (MUL/MULH/MULHSU/MULHU).
// Signed operands are converted to magnitudes when the operation is latched.
// An unsigned shift-add loop then runs for WIDTH cycles, and the sign is
// reapplied in a final FIX cycle that also loads the selected product half.
module shift_add_mul #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int AW = 2 * WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // Two's-complement magnitude on a WIDTH+1 path, so the most-negative value maps to 2^(WIDTH-1)
   function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
      logic [WIDTH:0] ext;
      ext = {is_signed & v[WIDTH-1], v};
      if (ext[WIDTH]) begin
         return ~ext + {{WIDTH{1'b0}}, 1'b1};
      end else begin
         return ext;
      end
   endfunction

   // Two's-complement negation of the full double-width product
   function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
      return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   state_t               state_r;
   state_t               state_next_s;
   logic [WIDTH:0]       mcand_r;
   logic [AW-1:0]        acc_r;
   logic [CW-1:0]        cnt_r;
   logic                 neg_r;
   logic [1:0]           op_r;
   logic                 busy_r;
   logic                 done_r;
   logic [WIDTH-1:0]     result_r;

   logic                 sign_a_s;
   logic                 sign_b_s;
   logic [WIDTH:0]       a_mag_s;
   logic [WIDTH:0]       b_mag_s;
   logic [WIDTH:0]       upper_sum_s;
   logic [AW-1:0]        acc_step_s;
   logic                 last_iter_s;
   logic [2*WIDTH-1:0]   product_s;
   logic                 busy_next_s;
   logic                 done_next_s;
   logic [WIDTH-1:0]     result_next_s;

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;

   // Operand sign handling: a is signed unless MULHU, and b is signed only for MUL/MULH
   always_comb begin
      sign_a_s = a[WIDTH-1] & (op != 2'b11);
      sign_b_s = b[WIDTH-1] & ~op[1];
      a_mag_s  = magnitude(a, op != 2'b11);
      b_mag_s  = magnitude(b, ~op[1]);
   end

   // One shift-add step: conditionally add the multiplicand to the upper half, then shift right
   always_comb begin
      upper_sum_s = acc_r[AW-1:WIDTH];
      if (acc_r[0]) begin
         upper_sum_s = acc_r[AW-1:WIDTH] + mcand_r;
      end else begin
         upper_sum_s = acc_r[AW-1:WIDTH];
      end
      acc_step_s  = {1'b0, upper_sum_s, acc_r[WIDTH-1:1]};
      last_iter_s = (cnt_r == CW'(WIDTH - 1));
   end

   // Signed product: reapply the sign to the unsigned magnitude product
   always_comb begin
      product_s = acc_r[2*WIDTH-1:0];
      if (neg_r) begin
         product_s = negate(acc_r[2*WIDTH-1:0]);
      end else begin
         product_s = acc_r[2*WIDTH-1:0];
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_CALC;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (last_iter_s) begin
               state_next_s = ST_FIX;
            end else begin
               state_next_s = ST_CALC;
            end
         end
         ST_FIX:  state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM output decode: next values of the registered busy/done/result
   always_comb begin
      busy_next_s   = busy_r;
      done_next_s   = 1'b0;
      result_next_s = result_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               busy_next_s = 1'b1;
            end else begin
               busy_next_s = 1'b0;
            end
         end
         ST_CALC: begin
            busy_next_s = 1'b1;
         end
         ST_FIX: begin
            busy_next_s = 1'b0;
            done_next_s = 1'b1;
            if (op_r == 2'b00) begin
               result_next_s = product_s[WIDTH-1:0];
            end else begin
               result_next_s = product_s[2*WIDTH-1:WIDTH];
            end
         end
         default: begin
            busy_next_s   = 1'b0;
            done_next_s   = 1'b0;
            result_next_s = result_r;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= {WIDTH{1'b0}};
      end else begin
         busy_r   <= busy_next_s;
         done_r   <= done_next_s;
         result_r <= result_next_s;
      end
   end

   // Datapath: latch magnitudes on accept, iterate in CALC, hold otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_r <= {(WIDTH+1){1'b0}};
         acc_r   <= {AW{1'b0}};
         cnt_r   <= {CW{1'b0}};
         neg_r   <= 1'b0;
         op_r    <= 2'b00;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  mcand_r <= a_mag_s;
                  acc_r   <= {{WIDTH{1'b0}}, b_mag_s};
                  cnt_r   <= {CW{1'b0}};
                  neg_r   <= sign_a_s ^ sign_b_s;
                  op_r    <= op;
               end else begin
                  mcand_r <= mcand_r;
                  acc_r   <= acc_r;
                  cnt_r   <= cnt_r;
                  neg_r   <= neg_r;
                  op_r    <= op_r;
               end
            end
            ST_CALC: begin
               acc_r <= acc_step_s;
               cnt_r <= cnt_r + CW'(1);
            end
            ST_FIX: begin
               acc_r <= acc_r;
               cnt_r <= cnt_r;
            end
            default: begin
               acc_r <= acc_r;
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mul.sv
// tb_shift_add_mul: self-checking bench for shift_add_mul (WIDTH=32).
// Expected products come from a plain 64-bit multiply of the sign/zero-extended
// operands. Inputs are driven and outputs are sampled on the falling clock edge.
module tb_shift_add_mul;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;

   int checks = 0;
   int errors = 0;

   shift_add_mul #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // Reference: RV32M semantics from the full-precision product
   function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] xe;
      logic [63:0] ye;
      logic [63:0] p;
      xe = (o != 2'b11) ? {{32{x[31]}}, x} : {32'h0000_0000, x};
      ye = (o[1] == 1'b0) ? {{32{y[31]}}, y} : {32'h0000_0000, y};
      p  = xe * ye;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Issue one operation. lat is the number of edges from the accepting edge to the done edge.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat, output bit busy_ok);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
      res = 32'h0; lat = -1; busy_ok = 1'b1;
      for (int k = 0; k <= W + 5; k++) begin
         if (done) begin
            lat = k; res = result;
            if (busy !== 1'b0) busy_ok = 1'b0;
            break;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] res; int lat; bit bok;
      run_op(2'b00, 32'd7, 32'd6, res, lat, bok);
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W + 1); end
      checks++; if (res !== 32'h0000_002A) begin errors++; $display("FAIL basic_result got=%h exp=0000002a", res); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", bok); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
      checks++; if (result !== 32'h0000_002A) begin errors++; $display("FAIL basic_result_hold got=%h exp=0000002a", result); end
   endtask

   task automatic test_corners();
      logic [1:0]  ov [6];
      logic [31:0] av [6];
      logic [31:0] bv [6];
      logic [31:0] ev [6];
      logic [31:0] res; int lat; bit bok;
      ov = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};
      av = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
      bv = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      ev = '{32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h4000_0000, 32'h8000_0000};
      for (int i = 0; i < 6; i++) begin
         run_op(ov[i], av[i], bv[i], res, lat, bok);
         checks++; if (res !== ev[i]) begin errors++; $display("FAIL corner_%0d result got=%h exp=%h", i, res, ev[i]); end
         checks++; if (lat !== W + 1) begin errors++; $display("FAIL corner_%0d latency got=%0d exp=%0d", i, lat, W + 1); end
      end
   endtask

   task automatic test_zero();
      logic [31:0] res; int lat; bit bok;
      for (int i = 0; i < 3; i++) begin
         run_op(2'($urandom), (i == 1) ? 32'($urandom) : 32'h0, (i == 0) ? 32'($urandom) : 32'h0, res, lat, bok);
         checks++; if (res !== 32'h0) begin errors++; $display("FAIL zero_%0d result got=%h exp=0", i, res); end
         checks++; if (lat !== W + 1) begin errors++; $display("FAIL zero_%0d latency got=%0d exp=%0d", i, lat, W + 1); end
      end
   endtask

   task automatic test_ignore_start();
      logic [1:0] o; logic [31:0] x; logic [31:0] y; logic [31:0] exp; logic [31:0] res; int lat;
      o = 2'($urandom); x = $urandom; y = $urandom; exp = ref_mul(o, x, y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      lat = -1; res = 32'h0;
      for (int k = 0; k <= W + 5; k++) begin
         if (done) begin lat = k; res = result; break; end
         if (k == 5 || k == 20) begin
            start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      checks++; if (res !== exp) begin errors++; $display("FAIL ignore_result got=%h exp=%h", res, exp); end
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, W + 1); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res; logic [31:0] exp; int lat; bit bok; bit saw_done;
      logic [31:0] x; logic [31:0] y;
      run_op(2'b00, 32'd5, 32'd5, res, lat, bok);
      checks++; if (res !== 32'd25) begin errors++; $display("FAIL rmid_pre got=%h exp=00000019", res); end
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL rmid_result got=%h exp=0", result); end
      saw_done = 1'b0;
      for (int k = 0; k < W + 4; k++) begin
         @(negedge clk);
         if (k == 2) rst = 1'b0;
         if (done) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rmid_no_done got=%b exp=0", saw_done); end
      x = $urandom; y = $urandom; exp = ref_mul(2'b10, x, y);
      run_op(2'b10, x, y, res, lat, bok);
      checks++; if (res !== exp) begin errors++; $display("FAIL rmid_after result got=%h exp=%h", res, exp); end
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL rmid_after latency got=%0d exp=%0d", lat, W + 1); end
   endtask

   // start held high: the next operation is accepted on the edge ending each done cycle
   task automatic test_back_to_back();
      int n; int ndone; int last;
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
      @(negedge clk);
      n = 0; ndone = 0; last = -1;
      while (ndone < 4 && n < 4 * (W + 2) + 10) begin
         if (done) begin
            checks++; if (result !== 32'h0000_000C) begin errors++; $display("FAIL b2b_%0d result got=%h exp=0000000c", ndone, result); end
            if (last < 0) begin
               checks++; if (n !== W + 1) begin errors++; $display("FAIL b2b_first got=%0d exp=%0d", n, W + 1); end
            end else begin
               checks++; if (n - last !== W + 2) begin errors++; $display("FAIL b2b_period got=%0d exp=%0d", n - last, W + 2); end
            end
            last = n; ndone++;
            if (ndone == 4) start = 1'b0;
         end
         if (ndone < 4) begin
            @(negedge clk);
            n++;
         end
      end
      start = 1'b0;
      checks++; if (ndone !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", ndone); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
   endtask

   function automatic logic [31:0] pick_operand();
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [1:0] o; logic [31:0] x; logic [31:0] y; logic [31:0] exp; logic [31:0] res; int lat; bit bok;
      for (int i = 0; i < 1000; i++) begin
         o = 2'($urandom_range(0, 3)); x = pick_operand(); y = pick_operand();
         exp = ref_mul(o, x, y);
         run_op(o, x, y, res, lat, bok);
         checks++; if (res !== exp) begin errors++; $display("FAIL rand_%0d op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, res, exp); end
         checks++; if (lat !== W + 1 || bok !== 1'b1) begin errors++; $display("FAIL rand_%0d timing lat=%0d busy_ok=%b exp lat=%0d busy_ok=1", i, lat, bok, W + 1); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_zero();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
